// File: rtl/ddio_out_pkg.sv
// ddio_out_pkg: shared constants and capture-control decode for the DDR output block.
//   WIDTH_DEFAULT  default data bus width
//   PRESET_ZERO/PRESET_ONE  per-bit clear / preset values
//   DISABLED_BIT   per-bit value driven on dataout while the output is disabled
//   cap_op()       rising-edge capture priority: hold > sclr > sset > data
// Build option: DDIO_OUT_TRISTATE_EN makes the disabled output high-impedance
// instead of zero.
package ddio_out_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    localparam logic PRESET_ZERO = 1'b0;
    localparam logic PRESET_ONE  = 1'b1;

`ifdef DDIO_OUT_TRISTATE_EN
    localparam logic DISABLED_BIT = 1'bz;
`else
    localparam logic DISABLED_BIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        CAP_HOLD = 2'd0,
        CAP_CLR  = 2'd1,
        CAP_SET  = 2'd2,
        CAP_DATA = 2'd3
    } cap_op_e;

    // Decode what the rising edge loads into the capture registers.
    function automatic cap_op_e cap_op(input logic clk_en, input logic sclr, input logic sset);
        cap_op_e op;
        op = CAP_HOLD;
        if (clk_en) begin
            if (sclr)      op = CAP_CLR;
            else if (sset) op = CAP_SET;
            else           op = CAP_DATA;
        end
        return op;
    endfunction

endpackage

// File: rtl/ddio_out_if.sv
// ddio_out_if: data/control bundle of the DDR output block.
//   datain_h/datain_l  data for the clk-high / clk-low half
//   clk_en, sclr, sset capture enable, synchronous clear / set
//   aset               asynchronous preset to all-ones
//   oe                 output enable request
//   dataout, oe_out    DDR output and registered output enable
// master: drives the inputs; slave: the ddio_out block.
interface ddio_out_if
    import ddio_out_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);
    logic [WIDTH-1:0] datain_h;
    logic [WIDTH-1:0] datain_l;
    logic [WIDTH-1:0] dataout;
    logic             clk_en;
    logic             aset;
    logic             sclr;
    logic             sset;
    logic             oe;
    logic             oe_out;

    modport master (
        output datain_h, datain_l, clk_en, aset, sclr, sset, oe,
        input  dataout, oe_out
    );

    modport slave (
        input  datain_h, datain_l, clk_en, aset, sclr, sset, oe,
        output dataout, oe_out
    );
endinterface

// File: rtl/ddio_out_cell.sv
// ddio_out_cell: one bit of the DDR output path.
//   clk     rising edge captures h/l, falling edge retimes the low half
//   aclr    async clear (wins over aset), aset async preset to one
//   clk_en, sclr, sset  synchronous capture control
//   d_h, d_l            high / low half data bit
//   dout_c  combinational DDR bit: h_q while clk high, l_n while clk low
module ddio_out_cell
    import ddio_out_pkg::*;
(
    input  logic clk,
    input  logic aclr,
    input  logic aset,
    input  logic clk_en,
    input  logic sclr,
    input  logic sset,
    input  logic d_h,
    input  logic d_l,
    output logic dout_c
);

    logic    h_q;
    logic    l_q;
    logic    l_n;
    cap_op_e op_c;

    always_comb begin
        op_c = cap_op(clk_en, sclr, sset);
    end

    // Rising-edge capture of both halves.
    always_ff @(posedge clk or posedge aclr or posedge aset) begin
        if (aclr) begin
            h_q <= PRESET_ZERO;
            l_q <= PRESET_ZERO;
        end else if (aset) begin
            h_q <= PRESET_ONE;
            l_q <= PRESET_ONE;
        end else begin
            unique case (op_c)
                CAP_CLR: begin
                    h_q <= PRESET_ZERO;
                    l_q <= PRESET_ZERO;
                end
                CAP_SET: begin
                    h_q <= PRESET_ONE;
                    l_q <= PRESET_ONE;
                end
                CAP_DATA: begin
                    h_q <= d_h;
                    l_q <= d_l;
                end
                default: begin
                    h_q <= h_q;
                    l_q <= l_q;
                end
            endcase
        end
    end

    // Low half is moved to the falling edge so it is stable for the whole clk-low phase.
    always_ff @(negedge clk or posedge aclr or posedge aset) begin
        if (aclr)      l_n <= PRESET_ZERO;
        else if (aset) l_n <= PRESET_ONE;
        else           l_n <= l_q;
    end

    assign dout_c = clk ? h_q : l_n;

endmodule

// File: rtl/ddio_out.sv
// ddio_out: WIDTH-bit double-data-rate output register with output enable.
//   clk   sole clock
//   aclr  asynchronous active-high clear (also disables the output)
//   bus   ddio_out_if.slave: datain_h/l, clk_en, aset, sclr, sset, oe in;
//         dataout, oe_out out
// Build option: DDIO_OUT_TRISTATE_EN selects high-impedance rather than zero
// on dataout while oe_out is low.
module ddio_out
    import ddio_out_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
)
(
    input  logic        clk,
    input  logic        aclr,
    ddio_out_if.slave   bus
);

    logic [WIDTH-1:0] cell_out_c;
    logic             oe_q;

    // One DDR cell per data bit.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        ddio_out_cell u_cell (
            .clk    (clk),
            .aclr   (aclr),
            .aset   (bus.aset),
            .clk_en (bus.clk_en),
            .sclr   (bus.sclr),
            .sset   (bus.sset),
            .d_h    (bus.datain_h[i]),
            .d_l    (bus.datain_l[i]),
            .dout_c (cell_out_c[i])
        );
    end

    // Output enable: follows clk_en but ignores sclr/sset and aset.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)            oe_q <= 1'b0;
        else if (bus.clk_en) oe_q <= bus.oe;
    end

    assign bus.oe_out  = oe_q;
    assign bus.dataout = oe_q ? cell_out_c : {WIDTH{DISABLED_BIT}};

endmodule

// File: tb/tb_ddio_out.sv
// tb_ddio_out: self-checking bench for ddio_out (WIDTH=8, 20 ns clock).
// Expected data pairs are queued when stimulus is applied and popped when
// the DUT presents the corresponding high/low halves.
module tb_ddio_out;

    localparam int unsigned W = 8;

`ifdef DDIO_OUT_TRISTATE_EN
    localparam logic [W-1:0] DIS = 8'hzz;
`else
    localparam logic [W-1:0] DIS = 8'h00;
`endif

    typedef struct packed {
        logic [W-1:0] h;
        logic [W-1:0] l;
    } pair_t;

    logic  clk;
    logic  aclr;
    pair_t sb[$];
    pair_t e;
    int    n_tests;
    int    n_fail;

    ddio_out_if #(.WIDTH(W)) bus ();

    ddio_out #(.WIDTH(W)) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Async clear held across both clock phases, then first capture.
    task automatic test_reset();
        aclr = 1'b1;
        bus.aset = 1'b0; bus.sclr = 1'b0; bus.sset = 1'b0;
        bus.clk_en = 1'b1; bus.oe = 1'b1;
        bus.datain_h = 8'hA5; bus.datain_l = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            #5;
            n_tests++;
            if (bus.dataout !== DIS) begin
                n_fail++; $display("FAIL reset_dout[%0d]: got %h want %h", i, bus.dataout, DIS);
            end
            n_tests++;
            if (bus.oe_out !== 1'b0) begin
                n_fail++; $display("FAIL reset_oe[%0d]: got %b want 0", i, bus.oe_out);
            end
            #5;
        end
        #5 aclr = 1'b0;
        sb.push_back('{8'hA5, 8'h3C});
        @(posedge clk); #5;
        e = sb.pop_front();
        n_tests++;
        if (bus.dataout !== e.h) begin
            n_fail++; $display("FAIL first_hi: got %h want %h", bus.dataout, e.h);
        end
        n_tests++;
        if (bus.oe_out !== 1'b1) begin
            n_fail++; $display("FAIL first_oe: got %b want 1", bus.oe_out);
        end
        @(negedge clk); #5;
        n_tests++;
        if (bus.dataout !== e.l) begin
            n_fail++; $display("FAIL first_lo: got %h want %h", bus.dataout, e.l);
        end
    endtask

    // Random data each cycle, then output disable.
    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            bus.datain_h = W'($urandom);
            bus.datain_l = W'($urandom);
            sb.push_back('{bus.datain_h, bus.datain_l});
            @(posedge clk); #5;
            e = sb.pop_front();
            n_tests++;
            if (bus.dataout !== e.h) begin
                n_fail++; $display("FAIL rand_hi[%0d]: got %h want %h", i, bus.dataout, e.h);
            end
            @(negedge clk); #5;
            n_tests++;
            if (bus.dataout !== e.l) begin
                n_fail++; $display("FAIL rand_lo[%0d]: got %h want %h", i, bus.dataout, e.l);
            end
        end
        bus.oe = 1'b0;
        @(posedge clk); #5;
        n_tests++;
        if (bus.oe_out !== 1'b0) begin
            n_fail++; $display("FAIL oe_off: got %b want 0", bus.oe_out);
        end
        n_tests++;
        if (bus.dataout !== DIS) begin
            n_fail++; $display("FAIL dis_hi: got %h want %h", bus.dataout, DIS);
        end
        @(negedge clk); #5;
        n_tests++;
        if (bus.dataout !== DIS) begin
            n_fail++; $display("FAIL dis_lo: got %h want %h", bus.dataout, DIS);
        end
        bus.oe = 1'b1;
    endtask

    // clk_en low: captured pair and oe_out hold while inputs change.
    task automatic test_clk_en();
        bus.datain_h = 8'h11; bus.datain_l = 8'h22;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{8'h11, 8'h22});
            @(posedge clk); #5;
            e = sb.pop_front();
            n_tests++;
            if (bus.dataout !== e.h) begin
                n_fail++; $display("FAIL hold_hi[%0d]: got %h want %h", i, bus.dataout, e.h);
            end
            n_tests++;
            if (bus.oe_out !== 1'b1) begin
                n_fail++; $display("FAIL hold_oe[%0d]: got %b want 1", i, bus.oe_out);
            end
            @(negedge clk); #5;
            n_tests++;
            if (bus.dataout !== e.l) begin
                n_fail++; $display("FAIL hold_lo[%0d]: got %h want %h", i, bus.dataout, e.l);
            end
            bus.clk_en = 1'b0;
            bus.oe = 1'b0;
            bus.datain_h = W'($urandom);
            bus.datain_l = W'($urandom);
        end
        bus.clk_en = 1'b1;
        bus.oe = 1'b1;
    endtask

    // Synchronous clear/set priority; gated by clk_en.
    task automatic test_sync();
        pair_t exp_tab[4];
        exp_tab[0] = '{8'h00, 8'h00};
        exp_tab[1] = '{8'hFF, 8'hFF};
        exp_tab[2] = '{8'hFF, 8'hFF};
        exp_tab[3] = '{8'hC3, 8'h5A};
        for (int i = 0; i < 4; i++) begin
            bus.sclr   = (i == 0) || (i == 2);
            bus.sset   = (i == 0) || (i == 1);
            bus.clk_en = (i != 2);
            bus.datain_h = (i == 3) ? 8'hC3 : W'($urandom);
            bus.datain_l = (i == 3) ? 8'h5A : W'($urandom);
            sb.push_back(exp_tab[i]);
            @(posedge clk); #5;
            e = sb.pop_front();
            n_tests++;
            if (bus.dataout !== e.h) begin
                n_fail++; $display("FAIL sync_hi[%0d]: got %h want %h", i, bus.dataout, e.h);
            end
            n_tests++;
            if (bus.oe_out !== 1'b1) begin
                n_fail++; $display("FAIL sync_oe[%0d]: got %b want 1", i, bus.oe_out);
            end
            @(negedge clk); #5;
            n_tests++;
            if (bus.dataout !== e.l) begin
                n_fail++; $display("FAIL sync_lo[%0d]: got %h want %h", i, bus.dataout, e.l);
            end
        end
        bus.sclr = 1'b0; bus.sset = 1'b0; bus.clk_en = 1'b1;
    endtask

    // Async preset mid-cycle, then aclr and aset together, then recovery.
    task automatic test_async();
        bus.datain_h = 8'h12; bus.datain_l = 8'h34;
        sb.push_back('{8'h12, 8'h34});
        @(posedge clk); #5;
        e = sb.pop_front();
        n_tests++;
        if (bus.dataout !== e.h) begin
            n_fail++; $display("FAIL pre_aset_hi: got %h want %h", bus.dataout, e.h);
        end
        @(negedge clk); #2;
        bus.aset = 1'b1;
        #1;
        n_tests++;
        if (bus.dataout !== 8'hFF) begin
            n_fail++; $display("FAIL aset_lo: got %h want ff", bus.dataout);
        end
        n_tests++;
        if (bus.oe_out !== 1'b1) begin
            n_fail++; $display("FAIL aset_oe: got %b want 1", bus.oe_out);
        end
        @(posedge clk); #5;
        n_tests++;
        if (bus.dataout !== 8'hFF) begin
            n_fail++; $display("FAIL aset_hi: got %h want ff", bus.dataout);
        end
        bus.aset = 1'b0;
        bus.datain_h = 8'h56; bus.datain_l = 8'h78;
        sb.push_back('{8'h56, 8'h78});
        @(negedge clk); #5;
        n_tests++;
        if (bus.dataout !== 8'hFF) begin
            n_fail++; $display("FAIL aset_rel_lo: got %h want ff", bus.dataout);
        end
        @(posedge clk); #5;
        e = sb.pop_front();
        n_tests++;
        if (bus.dataout !== e.h) begin
            n_fail++; $display("FAIL post_aset_hi: got %h want %h", bus.dataout, e.h);
        end
        @(negedge clk); #5;
        n_tests++;
        if (bus.dataout !== e.l) begin
            n_fail++; $display("FAIL post_aset_lo: got %h want %h", bus.dataout, e.l);
        end
        bus.aset = 1'b1;
        #1 aclr = 1'b1;
        #1;
        n_tests++;
        if (bus.dataout !== DIS) begin
            n_fail++; $display("FAIL both_lo: got %h want %h", bus.dataout, DIS);
        end
        n_tests++;
        if (bus.oe_out !== 1'b0) begin
            n_fail++; $display("FAIL both_oe: got %b want 0", bus.oe_out);
        end
        @(posedge clk); #2;
        n_tests++;
        if (bus.dataout !== DIS) begin
            n_fail++; $display("FAIL both_hi: got %h want %h", bus.dataout, DIS);
        end
        aclr = 1'b0;
        bus.aset = 1'b0;
        bus.datain_h = 8'h9A; bus.datain_l = 8'hBC;
        sb.push_back('{8'h9A, 8'hBC});
        @(posedge clk); #5;
        e = sb.pop_front();
        n_tests++;
        if (bus.dataout !== e.h) begin
            n_fail++; $display("FAIL recover_hi: got %h want %h", bus.dataout, e.h);
        end
        n_tests++;
        if (bus.oe_out !== 1'b1) begin
            n_fail++; $display("FAIL recover_oe: got %b want 1", bus.oe_out);
        end
        @(negedge clk); #5;
        n_tests++;
        if (bus.dataout !== e.l) begin
            n_fail++; $display("FAIL recover_lo: got %h want %h", bus.dataout, e.l);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_random();
        test_clk_en();
        test_sync();
        test_async();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
